seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: observes a scanned, multiplexed 8-digit 7-segment bus
// (active-low AN/SEG), waits for each digit/segment pair to settle, decodes
// the segment pattern to a hex nibble and keeps a per-digit register image.
//
// Handshake note: there is no valid/ready pairing here. Captures are
// reported through DIGIT_VALID (sticky per digit) and FRAME_DONE (one-cycle
// pulse when every digit has been captured since the previous pulse).
module seg_scan_decoder #(
  parameter int unsigned SETTLE = 16
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  AN_IN,
  input  logic [7:0]  SEG_IN,
  output logic [31:0] DIGITS,
  output logic [7:0]  DP,
  output logic [7:0]  DIGIT_VALID,
  output logic        FRAME_DONE,
  output logic        ERR,
  output logic [1:0]  STATE_DBG
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  an_s1_q, an_s2_q, seg_s1_q, seg_s2_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  lat_an_q, lat_an_d, lat_seg_q, lat_seg_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  dp_q, dp_d, valid_q, valid_d, seen_q, seen_d;
  logic        frame_q, frame_d, err_q, err_d;

  logic [7:0]  an_low;
  logic        an_onehot, an_blank, pair_same, eval_pair, capture, err_set;
  logic [2:0]  cap_idx;
  logic [4:0]  dec;

  // Active-low 7-segment pattern to {undecodable, nibble}.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:   seg_decode = {1'b0, 4'h0};
      7'h79:   seg_decode = {1'b0, 4'h1};
      7'h24:   seg_decode = {1'b0, 4'h2};
      7'h30:   seg_decode = {1'b0, 4'h3};
      7'h19:   seg_decode = {1'b0, 4'h4};
      7'h12:   seg_decode = {1'b0, 4'h5};
      7'h02:   seg_decode = {1'b0, 4'h6};
      7'h78:   seg_decode = {1'b0, 4'h7};
      7'h00:   seg_decode = {1'b0, 4'h8};
      7'h10:   seg_decode = {1'b0, 4'h9};
      7'h7F:   seg_decode = {1'b0, 4'hF};
      default: seg_decode = {1'b1, 4'hE};
    endcase
  endfunction

  // Classify the synchronized digit-enable bus and compare against the latched pair.
  always_comb begin
    an_low    = ~an_s2_q;
    an_onehot = (an_low != 8'd0) && ((an_low & (an_low - 8'd1)) == 8'd0);
    an_blank  = (an_s2_q == 8'hFF);
    pair_same = (an_s2_q == lat_an_q) && (seg_s2_q == lat_seg_q);
  end

  // Settle FSM: any pair change is re-evaluated the same cycle as if from IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_an_d  = lat_an_q;
    lat_seg_d = lat_seg_q;
    capture   = 1'b0;
    err_set   = 1'b0;
    eval_pair = 1'b0;
    case (state_q)
      S_IDLE: eval_pair = 1'b1;
      S_SETTLE: begin
        if (pair_same) begin
          if (({1'b0, cnt_q} + 9'd1) == 9'(SETTLE)) begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
          cnt_d = cnt_q + 8'd1;
        end else begin
          eval_pair = 1'b1;
        end
      end
      S_HOLD:  eval_pair = !pair_same;
      default: state_d = S_IDLE;
    endcase
    if (eval_pair) begin
      if (an_onehot) begin
        state_d   = S_SETTLE;
        cnt_d     = 8'd1;
        lat_an_d  = an_s2_q;
        lat_seg_d = seg_s2_q;
      end else begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        err_set = !an_blank;
      end
    end
  end

  // Capture datapath and frame tracking; a capture on the clear edge lands in the fresh mask.
  always_comb begin
    cap_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!lat_an_q[i]) cap_idx = 3'(i);
    end
    dec      = seg_decode(lat_seg_q[6:0]);
    digits_d = digits_q;
    dp_d     = dp_q;
    valid_d  = valid_q;
    frame_d  = (seen_q == 8'hFF);
    seen_d   = frame_d ? 8'h00 : seen_q;
    err_d    = err_q | err_set;
    if (capture) begin
      digits_d[{cap_idx, 2'b00} +: 4] = dec[3:0];
      dp_d[cap_idx]    = ~lat_seg_q[7];
      valid_d[cap_idx] = 1'b1;
      seen_d[cap_idx]  = 1'b1;
      err_d            = err_d | dec[4];
    end
  end

  // Input synchronizers (reset to the blank pattern) and all state registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      an_s1_q   <= 8'hFF;
      an_s2_q   <= 8'hFF;
      seg_s1_q  <= 8'hFF;
      seg_s2_q  <= 8'hFF;
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      lat_an_q  <= 8'hFF;
      lat_seg_q <= 8'hFF;
      digits_q  <= 32'd0;
      dp_q      <= 8'd0;
      valid_q   <= 8'd0;
      seen_q    <= 8'd0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      an_s1_q   <= AN_IN;
      an_s2_q   <= an_s1_q;
      seg_s1_q  <= SEG_IN;
      seg_s2_q  <= seg_s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_an_q  <= lat_an_d;
      lat_seg_q <= lat_seg_d;
      digits_q  <= digits_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
    end
  end

  assign DIGITS      = digits_q;
  assign DP          = dp_q;
  assign DIGIT_VALID = valid_q;
  assign FRAME_DONE  = frame_q;
  assign ERR         = err_q;
  assign STATE_DBG   = state_q;

endmodule
